// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per clock.
// Optional two's-complement mode: define ITER_MULDIV_SIGNED_EN.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef ITER_MULDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             commit;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;

  logic [WIDTH-1:0] fin_lo, fin_hi;
  logic             fin_dz;
  logic [WIDTH-1:0] a_ld, b_ld;

`ifdef ITER_MULDIV_SIGNED_EN
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] raw_a;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign a_ld = (op[1] && a[WIDTH-1]) ? WIDTH'('0 - a) : a;
  assign b_ld = (op[1] && b[WIDTH-1]) ? WIDTH'('0 - b) : b;
`else
  logic op_sign_unused;

  assign op_sign_unused = op[1];
  assign a_ld = a;
  assign b_ld = b;
`endif

  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide shifts the dividend out of acc_lo into the partial remainder in acc_hi.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
  end

  always_comb begin
    fin_dz = is_div && (opnd == '0);
    fin_lo = acc_lo;
    fin_hi = acc_hi;
`ifdef ITER_MULDIV_SIGNED_EN
    prod     = {acc_hi, acc_lo};
    prod_neg = '0 - prod;
    if (!is_div) begin
      if (neg_q) begin
        fin_hi = prod_neg[2*WIDTH-1:WIDTH];
        fin_lo = prod_neg[WIDTH-1:0];
      end
    end else if (fin_dz) begin
      fin_lo = '1;
      fin_hi = raw_a;
    end else begin
      if (neg_q) fin_lo = WIDTH'('0 - acc_lo);
      if (neg_r) fin_hi = WIDTH'('0 - acc_hi);
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (cnt == '0) begin
`ifdef ITER_MULDIV_SIGNED_EN
          state_nxt = FIX;
`else
          state_nxt = DONE;
          commit    = 1'b1;
`endif
        end
      end
`ifdef ITER_MULDIV_SIGNED_EN
      FIX: begin
        state_nxt = DONE;
        commit    = 1'b1;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      result_lo <= '0;
      result_hi <= '0;
      dz        <= 1'b0;
`ifdef ITER_MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      raw_a     <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        cnt    <= CW'(WIDTH);
        is_div <= op[0];
        acc_hi <= '0;
        acc_lo <= a_ld;
        opnd   <= b_ld;
`ifdef ITER_MULDIV_SIGNED_EN
        neg_q  <= op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= op[1] && a[WIDTH-1];
        raw_a  <= a;
`endif
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (is_div) begin
          acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end
      if (commit) begin
        result_lo <= fin_lo;
        result_hi <= fin_hi;
        dz        <= fin_dz;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed self-checking bench for iter_muldiv (WIDTH=8).
module tb_iter_muldiv;

`ifdef ITER_MULDIV_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, dz;
  logic [7:0] result_lo, result_hi;

  int total = 0;
  int bad = 0;

  iter_muldiv #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi), .dz(dz)
  );

  always #5 clk = ~clk;

  // Stimulus only: issue one request, scramble inputs afterwards, return edges to done (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if ({busy, done, dz} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {busy, done, dz}); end
    total++; if ({result_hi, result_lo} !== 16'h0000) begin bad++; $display("FAIL reset_res got=%h want=0000", {result_hi, result_lo}); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_multiply();
    int lat;
    run_op(2'b00, 8'd200, 8'd150, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", lat, LAT); end
    total++; if ({result_hi, result_lo} !== 16'h7530) begin bad++; $display("FAIL mul_result got=%h want=7530", {result_hi, result_lo}); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL mul_dz got=%b want=0", dz); end
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mul_after got=%b want=00", {busy, done}); end
  endtask

  task automatic test_divide();
    int lat;
    run_op(2'b01, 8'd200, 8'd7, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL div_latency got=%0d want=%0d", lat, LAT); end
    total++; if ({result_hi, result_lo} !== 16'h041C) begin bad++; $display("FAIL div_result got=%h want=041c", {result_hi, result_lo}); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL div_dz got=%b want=0", dz); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'b01, 8'h5A, 8'h00, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL dz_latency got=%0d want=%0d", lat, LAT); end
    total++; if ({result_hi, result_lo} !== 16'h5AFF) begin bad++; $display("FAIL dz_result got=%h want=5aff", {result_hi, result_lo}); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", dz); end
    run_op(2'b00, 8'd12, 8'd12, lat);
    total++; if ({result_hi, result_lo} !== 16'h0090) begin bad++; $display("FAIL dz_clr_result got=%h want=0090", {result_hi, result_lo}); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", dz); end
  endtask

  task automatic test_busy();
    int e;
    int pulses;
    @(posedge clk); #1;
    op = 2'b00; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; e = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_run got=%b want=1", busy); end
    repeat (3) begin @(posedge clk); #1; e++; end
    op = 2'b01; a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk); #1; e++;
    start = 1'b0;
    while (done !== 1'b1 && e < 20) begin @(posedge clk); #1; e++; end
    total++; if (e !== LAT) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", e, LAT); end
    total++; if ({result_hi, result_lo} !== 16'h008F) begin bad++; $display("FAIL busy_result got=%h want=008f", {result_hi, result_lo}); end
    op = 2'b01; a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL busy_ignored got=%0d want=0", pulses); end
    total++; if ({result_hi, result_lo} !== 16'h008F) begin bad++; $display("FAIL busy_hold got=%h want=008f", {result_hi, result_lo}); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    @(posedge clk); #1;
    op = 2'b01; a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++; if ({result_hi, result_lo} !== 16'h0000) begin bad++; $display("FAIL rstmid_res got=%h want=0000", {result_hi, result_lo}); end
    total++; if ({busy, done, dz} !== 3'b000) begin bad++; $display("FAIL rstmid_ctl got=%b want=000", {busy, done, dz}); end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", pulses); end
    run_op(2'b00, 8'd3, 8'd5, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL rstmid_lat got=%0d want=%0d", lat, LAT); end
    total++; if ({result_hi, result_lo} !== 16'h000F) begin bad++; $display("FAIL rstmid_result got=%h want=000f", {result_hi, result_lo}); end
  endtask

`ifdef ITER_MULDIV_SIGNED_EN
  task automatic test_signed();
    int lat;
    run_op(2'b10, 8'hF9, 8'h03, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL smul_latency got=%0d want=10", lat); end
    total++; if ({result_hi, result_lo} !== 16'hFFEB) begin bad++; $display("FAIL smul_result got=%h want=ffeb", {result_hi, result_lo}); end
    run_op(2'b11, 8'hF9, 8'h02, lat);
    total++; if ({result_hi, result_lo} !== 16'hFFFD) begin bad++; $display("FAIL sdiv_result got=%h want=fffd", {result_hi, result_lo}); end
    run_op(2'b11, 8'hF9, 8'h00, lat);
    total++; if ({dz, result_hi, result_lo} !== 17'h1F9FF) begin bad++; $display("FAIL sdz_result got=%h want=1f9ff", {dz, result_hi, result_lo}); end
  endtask
`endif

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_busy();
    test_reset_mid();
`ifdef ITER_MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
